// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left, parallel load, fill count.
// Define UNIV_SHIFT_REG_ROTATE_EN to add the rot input for circular shifts.
module univ_shift_reg #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       clear,
   input  logic                       en,
   input  logic [1:0]                 mode,
   input  logic [WIDTH-1:0]           sin_r,
   input  logic [WIDTH-1:0]           sin_l,
   input  logic [WIDTH*DEPTH-1:0]     pin,
`ifdef UNIV_SHIFT_REG_ROTATE_EN
   input  logic                       rot,
`endif
   output logic [WIDTH*DEPTH-1:0]     pout,
   output logic [WIDTH-1:0]           sout_r,
   output logic [WIDTH-1:0]           sout_l,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int TW = WIDTH*DEPTH;
   localparam logic [CW-1:0] LP_FULL = CW'(DEPTH);

   logic [TW-1:0]    r_data;
   logic [CW-1:0]    r_count;
   logic             r_full;

   logic             w_rot;
   logic [WIDTH-1:0] w_in_r;
   logic [WIDTH-1:0] w_in_l;
   logic [CW-1:0]    w_cnt_sh;
   logic [CW-1:0]    w_cnt_nx;
   logic [TW-1:0]    w_data_nx;

`ifdef UNIV_SHIFT_REG_ROTATE_EN
   assign w_rot = rot;
`else
   assign w_rot = 1'b0;
`endif

   // Rotation recirculates the outgoing stage and leaves the fill count alone.
   assign w_in_r = w_rot ? r_data[TW-1 -: WIDTH] : sin_r;
   assign w_in_l = w_rot ? r_data[WIDTH-1:0] : sin_l;

   assign w_cnt_sh = (w_rot || r_count == LP_FULL) ?
                     r_count : r_count + CW'(1);

   always_comb begin
      w_data_nx = r_data;
      w_cnt_nx  = r_count;
      case (mode)
         2'b01: begin
            w_data_nx = {r_data[TW-WIDTH-1:0], w_in_r};
            w_cnt_nx  = w_cnt_sh;
         end
         2'b10: begin
            w_data_nx = {w_in_l, r_data[TW-1:WIDTH]};
            w_cnt_nx  = w_cnt_sh;
         end
         2'b11: begin
            w_data_nx = pin;
            w_cnt_nx  = LP_FULL;
         end
         default: begin
            w_data_nx = r_data;
            w_cnt_nx  = r_count;
         end
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         r_data  <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
      end else if (en) begin
         r_data  <= w_data_nx;
         r_count <= w_cnt_nx;
         r_full  <= (w_cnt_nx == LP_FULL);
      end
   end

   assign pout   = r_data;
   assign sout_r = r_data[TW-1 -: WIDTH];
   assign sout_l = r_data[WIDTH-1:0];
   assign count  = r_count;
   assign full   = r_full;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: queue-based stage model checked every cycle,
// plus directed literal expectations.
module tb_univ_shift_reg;

   localparam int W  = 8;
   localparam int D  = 4;
   localparam int CW = $clog2(D+1);

   logic            clock;
   logic            clear;
   logic            en;
   logic [1:0]      mode;
   logic [W-1:0]    sin_r;
   logic [W-1:0]    sin_l;
   logic [W*D-1:0]  pin;
   logic            rot;
   logic [W*D-1:0]  pout;
   logic [W-1:0]    sout_r;
   logic [W-1:0]    sout_l;
   logic [CW-1:0]   count;
   logic            full;

   int checks = 0;
   int errors = 0;

   univ_shift_reg #(.WIDTH(W), .DEPTH(D)) dut (
      .clock (clock),
      .clear (clear),
      .en    (en),
      .mode  (mode),
      .sin_r (sin_r),
      .sin_l (sin_l),
      .pin   (pin),
`ifdef UNIV_SHIFT_REG_ROTATE_EN
      .rot   (rot),
`endif
      .pout  (pout),
      .sout_r(sout_r),
      .sout_l(sout_l),
      .count (count),
      .full  (full)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Model: queue index k is stage k; count is plain integer fill level.
   logic [W-1:0] m_q[$];
   int           m_cnt;

   function automatic void m_reset();
      m_q.delete();
      for (int k = 0; k < D; k++) m_q.push_back('0);
      m_cnt = 0;
   endfunction

   initial m_reset();

   always @(posedge clock or negedge clear) begin
      if (!clear) begin
         m_reset();
      end else if (en) begin
         logic rot_now;
         logic [W-1:0] t;
         rot_now = 1'b0;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
         rot_now = rot;
`endif
         if (mode == 2'b01) begin
            t = rot_now ? m_q[D-1] : sin_r;
            m_q.push_front(t);
            void'(m_q.pop_back());
            if (!rot_now && m_cnt < D) m_cnt++;
         end else if (mode == 2'b10) begin
            t = rot_now ? m_q[0] : sin_l;
            m_q.push_back(t);
            void'(m_q.pop_front());
            if (!rot_now && m_cnt < D) m_cnt++;
         end else if (mode == 2'b11) begin
            for (int k = 0; k < D; k++) m_q[k] = pin[k*W +: W];
            m_cnt = D;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, got, exp,
                  $time);
      end
   endtask

   always @(negedge clock) begin
      logic [W*D-1:0] ep;
      for (int k = 0; k < D; k++) ep[k*W +: W] = m_q[k];
      chk("model_pout", 32'(pout), 32'(ep));
      chk("model_sout_r", 32'(sout_r), 32'(m_q[D-1]));
      chk("model_sout_l", 32'(sout_l), 32'(m_q[0]));
      chk("model_count", 32'(count), 32'(m_cnt));
      chk("model_full", 32'(full), 32'(m_cnt == D));
   end

   // Inputs change 1 time unit after a rising edge; returns just after next.
   task automatic step(input logic e, input logic [1:0] m,
                       input logic [W-1:0] sr, input logic [W-1:0] sl,
                       input logic [W*D-1:0] p, input logic r);
      en    = e;
      mode  = m;
      sin_r = sr;
      sin_l = sl;
      pin   = p;
      rot   = r;
      @(posedge clock);
      #1;
   endtask

   task automatic clear_pulse(input string tag);
      #2 clear = 1'b0;
      #1;
      chk({tag, "_pout0"}, 32'(pout), 32'h0);
      chk({tag, "_count0"}, 32'(count), 32'h0);
      chk({tag, "_full0"}, 32'(full), 32'h0);
      #3 clear = 1'b1;
   endtask

   logic [7:0] sr_vec[4];

   initial begin
      clear = 1'b0;
      en = 1'b0; mode = 2'b00; sin_r = '0; sin_l = '0; pin = '0;
      rot = 1'b0;
      sr_vec = '{8'h11, 8'h22, 8'h33, 8'h44};
      @(posedge clock); #1;
      en = 1'b1; mode = 2'b11; pin = 32'hDEADBEEF;
      @(posedge clock); #1;
      chk("reset_ignores_inputs", 32'(pout), 32'h0);
      clear = 1'b1;

      for (int i = 0; i < 4; i++)
         step(1, 2'b01, sr_vec[i], 8'h00, '0, 0);
      chk("sr_pout", 32'(pout), 32'h11223344);
      chk("sr_sout_r", 32'(sout_r), 32'h11);
      chk("sr_count", 32'(count), 32'd4);
      chk("sr_full", 32'(full), 32'd1);

      step(1, 2'b01, 8'h55, 8'h00, '0, 0);
      chk("sat_count", 32'(count), 32'd4);
      chk("sat_pout", 32'(pout), 32'h22334455);

      clear_pulse("async");
      step(1, 2'b01, 8'h9C, 8'h00, '0, 0);
      chk("first_count", 32'(count), 32'd1);
      chk("first_full", 32'(full), 32'd0);

      step(1, 2'b11, 8'h00, 8'h00, 32'hA3A2A1A0, 0);
      chk("load_pout", 32'(pout), 32'hA3A2A1A0);
      chk("load_count", 32'(count), 32'd4);
      step(1, 2'b10, 8'h00, 8'h5F, '0, 0);
      chk("sl_pout", 32'(pout), 32'h5FA3A2A1);
      chk("sl_sout_l", 32'(sout_l), 32'hA1);
      chk("sl_count", 32'(count), 32'd4);

      for (int i = 0; i < 3; i++) step(0, 2'b01, 8'hEE, 8'hEE, '1, 0);
      chk("hold_en0_pout", 32'(pout), 32'h5FA3A2A1);
      for (int i = 0; i < 2; i++) step(1, 2'b00, 8'hEE, 8'hEE, '1, 0);
      chk("hold_m00_pout", 32'(pout), 32'h5FA3A2A1);
      chk("hold_count", 32'(count), 32'd4);

      clear_pulse("pre");
      step(1, 2'b01, 8'h12, 8'h00, '0, 0);
      step(1, 2'b01, 8'h34, 8'h00, '0, 0);
      chk("mid_count2", 32'(count), 32'd2);
      en = 1'b1; mode = 2'b01; sin_r = 8'h56;
      clear_pulse("mid");
      step(1, 2'b01, 8'h77, 8'h00, '0, 0);
      chk("mid_pout", 32'(pout), 32'h00000077);
      chk("mid_count", 32'(count), 32'd1);

      step(1, 2'b10, 8'h00, 8'hC1, '0, 0);
      step(1, 2'b10, 8'h00, 8'hC2, '0, 0);
      chk("sl_fill_count", 32'(count), 32'd3);
      chk("sl_fill_pout", 32'(pout), 32'hC2C10000);

      step(1, 2'b11, 8'h00, 8'h00, 32'h04030201, 0);
`ifdef UNIV_SHIFT_REG_ROTATE_EN
      for (int i = 0; i < 4; i++) step(1, 2'b01, 8'hFF, 8'hFF, '0, 1);
      chk("rot_pout", 32'(pout), 32'h04030201);
      chk("rot_count", 32'(count), 32'd4);
      step(1, 2'b01, 8'hFF, 8'hFF, '0, 1);
      chk("rot_r1", 32'(pout), 32'h03020104);
      step(1, 2'b10, 8'hFF, 8'hFF, '0, 1);
      chk("rot_l1", 32'(pout), 32'h04030201);
      clear_pulse("rotclr");
      step(1, 2'b01, 8'h66, 8'h00, '0, 1);
      chk("rot_cnt_hold", 32'(count), 32'd0);
`else
      for (int i = 0; i < 4; i++) step(1, 2'b01, 8'h00, 8'hFF, '0, 1);
      chk("norot_pout", 32'(pout), 32'h0);
      chk("norot_count", 32'(count), 32'd4);
`endif

      @(negedge clock);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
